// File: rtl/uart_rx_oversampler.sv
// 8N1 UART receiver, 16x oversampled; byte lands in a valid/ready holding register ~9.5 bit times after the start edge.
// No stall path: an unconsumed byte is overwritten by the next good frame and UART_Overrun pulses.
module uart_rx_oversampler #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       rx_busy,
  output logic       UART_Error,
  output logic       UART_Overrun
);

  localparam int DIVISOR = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  if (DIVISOR < 1) begin : g_bad_divisor
    $error("uart_rx_oversampler: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
  end
  if (OVERSAMPLE != 16) begin : g_bad_oversample
    $error("uart_rx_oversampler: OVERSAMPLE must be 16");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          rx_meta;
  logic          rx_s;
  state_t        state;
  logic [3:0]    s_cnt;
  logic [2:0]    b_idx;
  logic [7:0]    shreg;

  assign tick = (div_cnt == DW'(DIVISOR - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Idle-high reset value keeps a freshly released receiver from seeing a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      s_cnt        <= '0;
      b_idx        <= '0;
      shreg        <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      rx_busy      <= 1'b0;
      UART_Error   <= 1'b0;
      UART_Overrun <= 1'b0;
    end else begin
      UART_Error   <= 1'b0;
      UART_Overrun <= 1'b0;
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            s_cnt   <= '0;
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (s_cnt == 4'd7) begin
              if (!rx_s) begin
                s_cnt <= '0;
                b_idx <= '0;
                state <= DATA;
              end else begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_cnt == 4'd15) begin
              shreg <= {rx_s, shreg[7:1]};
              s_cnt <= '0;
              b_idx <= b_idx + 3'd1;
              if (b_idx == 3'd7) begin
                state <= STOP;
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s_cnt == 4'd15) begin
              if (rx_s) begin
                // A same-cycle consume frees the register, so that load is not an overrun.
                data_out     <= shreg;
                data_valid   <= 1'b1;
                UART_Overrun <= data_valid && !data_ready;
                state        <= IDLE;
                rx_busy      <= 1'b0;
              end else begin
                UART_Error <= 1'b1;
                state      <= BREAK;
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed 8N1 frames at DIVISOR=2 (32 clk/bit); expected bytes are queued by stimulus and popped by a negedge monitor on each accept.
module tb_uart_rx_oversampler;

  localparam int BIT_CLK = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       RX = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       rx_busy;
  logic       UART_Error;
  logic       UART_Overrun;

  int n_vec = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] exp_q[$];

  logic prev_dv = 1'b0;
  logic prev_busy = 1'b0;
  logic prev_err = 1'b0;
  logic prev_ovr = 1'b0;

  uart_rx_oversampler #(
    .CLK_FREQ  (3_200_000),
    .BAUD_RATE (100_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .rx_busy     (rx_busy),
    .UART_Error  (UART_Error),
    .UART_Overrun(UART_Overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // RX is left at the stop-bit value so a low stop bit can be stretched into a break.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    cyc(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      cyc(BIT_CLK);
    end
    RX = stop;
    cyc(BIT_CLK);
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 4 * BIT_CLK) begin
      cyc(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_dv   = 1'b0;
      prev_busy = 1'b0;
      prev_err  = 1'b0;
      prev_ovr  = 1'b0;
    end else begin
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte", data_out);
        end else begin
          check("rx_byte", data_out, exp_q.pop_front());
        end
      end
      if (!prev_dv && data_valid) check("busy_fall_on_valid", {prev_busy, rx_busy}, 2'b10);
      if (UART_Error || UART_Overrun) check("pulse_exclusive", UART_Error & UART_Overrun, 0);
      if (UART_Error) begin
        err_cnt++;
        check("err_width", prev_err, 0);
      end
      if (UART_Overrun) begin
        ovr_cnt++;
        check("ovr_width", prev_ovr, 0);
      end
      prev_dv   = data_valid;
      prev_busy = rx_busy;
      prev_err  = UART_Error;
      prev_ovr  = UART_Overrun;
    end
  end

  initial begin
    rst = 1'b0;
    RX = 1'b1;
    data_ready = 1'b0;
    cyc(5);
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_valid", data_valid, 0);
    check("rst_rx_busy", rx_busy, 0);
    check("rst_error", UART_Error, 0);
    check("rst_overrun", UART_Overrun, 0);
    rst = 1'b1;
    cyc(10);
    check("idle_valid", data_valid, 0);
    check("idle_busy", rx_busy, 0);

    data_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_drained("a5_drained");
    cyc(2);
    check("a5_valid_cleared", data_valid, 0);
    check("a5_no_err", err_cnt, 0);
    check("a5_no_ovr", ovr_cnt, 0);

    data_ready = 1'b0;
    cyc(BIT_CLK);
    send_frame(8'h3C, 1'b1);
    cyc(4);
    check("bp_first_valid", data_valid, 1);
    check("bp_first_data", data_out, 8'h3C);
    check("bp_first_no_ovr", ovr_cnt, 0);
    exp_q.push_back(8'hC3);
    cyc(BIT_CLK);
    send_frame(8'hC3, 1'b1);
    cyc(4);
    check("bp_ovr_count", ovr_cnt, 1);
    check("bp_second_data", data_out, 8'hC3);
    check("bp_valid_held", data_valid, 1);
    data_ready = 1'b1;
    cyc(1);
    check("bp_valid_clear", data_valid, 0);
    check("bp_drained", exp_q.size(), 0);

    cyc(BIT_CLK);
    send_frame(8'h55, 1'b0);
    cyc(3 * BIT_CLK);
    check("brk_err_count", err_cnt, 1);
    check("brk_busy", rx_busy, 1);
    check("brk_no_valid", data_valid, 0);
    RX = 1'b1;
    cyc(6);
    check("brk_idle", rx_busy, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_drained("x81_drained");
    check("x81_err_count", err_cnt, 1);

    cyc(BIT_CLK);
    RX = 1'b0;
    cyc(4);
    check("glitch_busy", rx_busy, 1);
    RX = 1'b1;
    cyc(BIT_CLK);
    check("glitch_idle", rx_busy, 0);
    check("glitch_no_valid", data_valid, 0);
    check("glitch_no_err", err_cnt, 1);

    cyc(BIT_CLK);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        cyc(5 * BIT_CLK + 8);
        rst = 1'b0;
        cyc(5);
        check("midrst_busy", rx_busy, 0);
        check("midrst_valid", data_valid, 0);
        rst = 1'b1;
      end
    join
    cyc(BIT_CLK);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    wait_drained("x12_drained");
    check("midrst_no_err", err_cnt, 1);
    check("final_ovr_count", ovr_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampler.md
# uart_rx_oversampler

Standalone UART receiver with 16x oversampling, the receive end of the team's UART link. It synchronises the asynchronous RX line, qualifies start bits at mid-bit and samples 8N1 frames LSB-first. Each good byte is presented to the consumer through a valid/ready holding register, and framing and overrun errors are reported as single-cycle pulses. It sits between the pad-side RX pin and any byte-oriented consumer (FIFO, command parser).

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD_RATE, 9600, line baud rate
- OVERSAMPLE, 16, ticks per bit period; fixed at 16
- DIVISOR (localparam), CLK_FREQ/(BAUD_RATE*OVERSAMPLE) floored, clocks per tick; elaboration error if < 1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- RX  in  1  serial line, idle high, asynchronous to clk
- data_out  out  8  received byte, held stable while data_valid=1
- data_valid  out  1  data_out holds an unconsumed byte
- data_ready  in  1  consumer accepts byte when data_valid & data_ready
- rx_busy  out  1  high whenever state != IDLE
- UART_Error  out  1  1-cycle pulse: stop bit sampled 0 (framing error)
- UART_Overrun  out  1  1-cycle pulse: good byte completed while the previous byte was unconsumed

## Operation
- RX goes through a 2-flop synchroniser (reset value 1); all logic uses the synchronised bit rx_s.
- Tick generator: free-running counter 0..DIVISOR-1; tick = 1 for one clk when counter == DIVISOR-1.
- FSM states: IDLE, START, DATA, STOP, BREAK. Sample counter s_cnt is 4 bits; bit index b_idx is 3 bits.
- IDLE: when rx_s == 0, clear s_cnt and go to START. No tick is required to leave IDLE.
- START: s_cnt increments on each tick. On the tick where s_cnt == 7 (mid start bit):
  - rx_s == 0: clear s_cnt and b_idx, go to DATA.
  - rx_s == 1: glitch; return to IDLE with no flag.
- DATA: s_cnt increments on each tick. On the tick where s_cnt == 15:
  - shift rx_s in at the MSB and shift right, so LSB-first order is recovered;
  - clear s_cnt and increment b_idx;
  - after b_idx 7, go to STOP.
- STOP: on the tick where s_cnt == 15, sample the stop bit:
  - rx_s == 1: the byte is good. Load the holding register, set data_valid, go to IDLE. If data_valid was already 1 and is not being consumed in that same cycle, pulse UART_Overrun; the new byte overwrites the old one.
  - rx_s == 0: pulse UART_Error, discard the byte (holding register and data_valid unchanged), go to BREAK.
- BREAK: wait until rx_s == 1, then go to IDLE. This prevents a held-low line from retriggering.
- Handshake: data_valid clears on the cycle after data_valid & data_ready. If consume and load happen in the same cycle, data_valid stays 1 with the new byte and no overrun is reported.
- data_ready is ignored while data_valid == 0.

## Timing
- Reset values (rst == 0, asynchronous): data_out = 0x00, data_valid = 0, rx_busy = 0, UART_Error = 0, UART_Overrun = 0, FSM = IDLE, synchroniser = 1, all counters = 0.
- Reset asserted mid-frame aborts the frame silently; no error pulse occurs after release.
- RX falling edge to IDLE→START: 2–3 clk (synchroniser).
- Start qualification: 8 ticks after START entry. Each data bit is sampled 16 ticks after the previous sample point.
- data_valid rises 1 clk after the stop-bit sample tick. Nominal latency from the RX falling edge is about 9.5 bit periods + 3 clk.
- Tick phase is free-running, so sample-point jitter is ≤ 1 tick (1/16 bit).
- UART_Error and UART_Overrun are exactly 1 clk wide; they never assert in the same cycle.
- data_out changes only on the cycle data_valid is (re)loaded.

## Test plan
Benches use CLK_FREQ = 3_200_000 and BAUD_RATE = 100_000, giving DIVISOR = 2 and a bit period of 32 clk.
- Reset: hold rst = 0 for 5 clk with RX = 1 → all outputs at reset values; release → outputs stay idle and rx_busy = 0.
- Single byte: send 0xA5 as an 8N1 frame with data_ready = 1 → data_valid pulses for 1 clk with data_out = 0xA5, no error pulses, rx_busy falls when data_valid rises.
- Back-pressure and overrun:
  - send 0x3C then 0xC3 with data_ready = 0 → data_out = 0x3C after the first frame; one UART_Overrun pulse at the second stop sample; data_out = 0xC3 and data_valid stays 1;
  - raise data_ready → data_valid clears next clk.
- Framing/break: send 0x55 with stop bit 0, then hold RX low for 3 bit periods, then high → one UART_Error pulse; data_valid stays 0; FSM in BREAK until RX is high, then IDLE; a following 0x81 frame is received correctly.
- Glitch rejection: drive a RX low pulse of 4 clk (< half bit) → FSM returns to IDLE, no data_valid, no error pulses.
- Reset mid-frame: assert rst during bit 4 of a 0xFF frame, release, then send 0x12 → only 0x12 is delivered; no UART_Error is reported for the aborted frame.
